// File: rtl/cmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmem_pkg
// Description : Shared constants, state and tag types for the cmem sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cmem_pkg;

    localparam int   CMEM_AW    = 6;
    localparam int   CMEM_DW    = 16;
    localparam int   CMEM_LANES = 6;
    localparam int   CMEM_DEPTH = 64;

    // cmem strobes are active-low
    localparam logic CMEM_ON    = 1'b0;
    localparam logic CMEM_OFF   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } cmem_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  first;
        logic                  last;
        logic [CMEM_LANES-1:0] lane_en;
    } cmem_tag_t;

endpackage
`default_nettype wire

// File: rtl/cmem_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cmem_tag_pipe
// Description : Two-stage delay line aligning beat tags with cmem Q outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cmem_tag_pipe
    import cmem_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  cmem_tag_t tag_in,
    output cmem_tag_t tag_out
);

    cmem_tag_t r_s1;
    cmem_tag_t r_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= tag_in;
            r_s2 <= r_s1;
        end
    end

    assign tag_out = r_s2;

endmodule
`default_nettype wire

// File: rtl/cmem_seq.sv
`default_nettype none
// ============================================================================
// Module      : cmem_seq
// Description : Coefficient loader and 6-lane read sweeper for cmem, with tags.
// Revision    : 1.0 - initial release
// ============================================================================
module cmem_seq
    import cmem_pkg::*;
#(
    parameter int DEPTH = CMEM_DEPTH,
    parameter int AW    = CMEM_AW,
    parameter int DW    = CMEM_DW,
    parameter int LANES = CMEM_LANES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [DW-1:0]    coef_data,
    input  logic             coef_last,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             busy,
    output logic             taps_loaded,
    output logic [AW:0]      ntaps,
    output logic [DW-1:0]    mem_d,
    output logic [AW-1:0]    mem_a0,
    output logic [AW-1:0]    mem_a1,
    output logic [AW-1:0]    mem_a2,
    output logic [AW-1:0]    mem_a3,
    output logic [AW-1:0]    mem_a4,
    output logic [AW-1:0]    mem_a5,
    output logic             mem_wen,
    output logic             mem_cen,
    output logic             q_valid,
    output logic             q_first,
    output logic             q_last,
    output logic [LANES-1:0] q_lane_en
);

    localparam logic [AW:0]   c_step  = (AW+1)'(LANES);
    localparam logic [AW:0]   c_one   = (AW+1)'(1);
    localparam logic [AW-1:0] c_wone  = AW'(1);
    localparam logic [AW-1:0] c_wlast = AW'(DEPTH-1);

    cmem_state_t   r_state;
    logic [AW-1:0] r_waddr;
    logic [AW:0]   r_base;
    logic [AW:0]   r_ntaps;
    logic          r_loaded;
    logic [AW-1:0] r_addr [LANES];
    logic [DW-1:0] r_d;
    logic          r_wen;
    logic          r_cen;

    logic          w_coef_fire;
    logic          w_sample_fire;
    logic          w_sweep_done;
    logic          w_issue;
    logic          w_final;
    logic [AW-1:0] w_wa;
    logic [AW:0]   w_beat_base;
    logic [AW-1:0] w_addr_next [LANES];
    cmem_tag_t     w_tag;
    cmem_tag_t     w_q_tag;

    assign coef_ready    = (r_state != RUN);
    // A pending coefficient beat always beats a sample offered in IDLE
    assign sample_ready  = (r_state == IDLE) && r_loaded && !coef_valid;
    assign busy          = (r_state != IDLE);
    assign w_coef_fire   = coef_valid && coef_ready;
    assign w_sample_fire = sample_valid && sample_ready;

    assign w_wa          = (r_state == IDLE) ? '0 : r_waddr;
    assign w_final       = coef_last || (w_wa == c_wlast);

    // Beat 0 is issued on the accepting edge; RUN then ends one cycle after the last beat
    assign w_beat_base   = (r_state == RUN) ? r_base : '0;
    assign w_sweep_done  = (r_state == RUN) && (r_base >= r_ntaps);
    assign w_issue       = w_sample_fire || ((r_state == RUN) && !w_sweep_done);

    always_comb begin
        w_tag = '0;
        for (int i = 0; i < LANES; i++) begin
            w_addr_next[i] = AW'(w_beat_base + (AW+1)'(i));
        end
        if (w_issue) begin
            w_tag.valid = 1'b1;
            w_tag.first = (w_beat_base == '0);
            w_tag.last  = ((w_beat_base + c_step) >= r_ntaps);
            for (int i = 0; i < LANES; i++) begin
                w_tag.lane_en[i] = ((w_beat_base + (AW+1)'(i)) < r_ntaps);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_waddr  <= '0;
            r_base   <= '0;
            r_ntaps  <= '0;
            r_loaded <= 1'b0;
            r_d      <= '0;
            r_wen    <= CMEM_OFF;
            r_cen    <= CMEM_OFF;
            for (int i = 0; i < LANES; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            r_wen <= CMEM_OFF;
            r_cen <= CMEM_OFF;
            if (w_coef_fire) begin
                r_addr[0] <= w_wa;
                r_d       <= coef_data;
                r_wen     <= CMEM_ON;
                r_cen     <= CMEM_ON;
                r_waddr   <= w_wa + c_wone;
                if (w_final) begin
                    r_ntaps  <= {1'b0, w_wa} + c_one;
                    r_loaded <= 1'b1;
                    r_state  <= IDLE;
                end else begin
                    r_loaded <= 1'b0;
                    r_state  <= LOAD;
                end
            end else if (w_issue) begin
                for (int i = 0; i < LANES; i++) begin
                    r_addr[i] <= w_addr_next[i];
                end
                r_cen   <= CMEM_ON;
                r_base  <= w_beat_base + c_step;
                r_state <= RUN;
            end else if (w_sweep_done) begin
                r_state <= IDLE;
            end
        end
    end

    cmem_tag_pipe u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (w_tag),
        .tag_out (w_q_tag)
    );

    assign taps_loaded = r_loaded;
    assign ntaps       = r_ntaps;
    assign mem_d       = r_d;
    assign mem_a0      = r_addr[0];
    assign mem_a1      = r_addr[1];
    assign mem_a2      = r_addr[2];
    assign mem_a3      = r_addr[3];
    assign mem_a4      = r_addr[4];
    assign mem_a5      = r_addr[5];
    assign mem_wen     = r_wen;
    assign mem_cen     = r_cen;
    assign q_valid     = w_q_tag.valid;
    assign q_first     = w_q_tag.first;
    assign q_last      = w_q_tag.last;
    assign q_lane_en   = w_q_tag.lane_en;

endmodule
`default_nettype wire

// File: tb/tb_cmem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmem_seq
// Description : Self-checking bench for cmem_seq with a behavioural cmem model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmem_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coef_valid = 1'b0;
    logic [15:0] coef_data = '0;
    logic        coef_last = 1'b0;
    logic        sample_valid = 1'b0;
    logic        coef_ready, sample_ready, busy, taps_loaded;
    logic [6:0]  ntaps;
    logic [15:0] mem_d;
    logic [5:0]  mem_a0, mem_a1, mem_a2, mem_a3, mem_a4, mem_a5;
    logic        mem_wen, mem_cen, q_valid, q_first, q_last;
    logic [5:0]  q_lane_en;

    always #5 clk = ~clk;

    cmem_seq dut (
        .clk(clk), .rst(rst),
        .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_last(coef_last),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .taps_loaded(taps_loaded), .ntaps(ntaps),
        .mem_d(mem_d),
        .mem_a0(mem_a0), .mem_a1(mem_a1), .mem_a2(mem_a2),
        .mem_a3(mem_a3), .mem_a4(mem_a4), .mem_a5(mem_a5),
        .mem_wen(mem_wen), .mem_cen(mem_cen),
        .q_valid(q_valid), .q_first(q_first), .q_last(q_last),
        .q_lane_en(q_lane_en)
    );

    // Behavioural 6-read-port, 1-write-port memory standing in for cmem
    logic [5:0]  ma [6];
    logic [15:0] cm [64];
    logic [15:0] cq [6];
    assign ma[0] = mem_a0;
    assign ma[1] = mem_a1;
    assign ma[2] = mem_a2;
    assign ma[3] = mem_a3;
    assign ma[4] = mem_a4;
    assign ma[5] = mem_a5;

    always @(posedge clk) begin
        if (mem_cen == 1'b0 && mem_wen == 1'b0) cm[mem_a0] <= mem_d;
        if (mem_cen == 1'b0 && mem_wen == 1'b1) begin
            for (int i = 0; i < 6; i++) cq[i] <= cm[ma[i]];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference view of the sequencer, derived from the load/sweep rules
    int          ref_ntaps = 0;
    bit          ref_loaded = 1'b0;
    bit          ref_loading = 1'b0;
    int          ref_cnt = 0;
    logic [15:0] ref_coef [64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_reset();
        ref_ntaps   = 0;
        ref_loaded  = 1'b0;
        ref_loading = 1'b0;
        ref_cnt     = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_coef_ready"}, coef_ready, 1);
        chk({tag, "_sample_ready"}, sample_ready, 0);
        chk({tag, "_taps_loaded"}, taps_loaded, 0);
        chk({tag, "_ntaps"}, ntaps, 0);
        chk({tag, "_cen_wen"}, {mem_cen, mem_wen}, 2'b11);
        chk({tag, "_addrs"}, {mem_a0, mem_a1, mem_a2, mem_a3, mem_a4, mem_a5}, 0);
        chk({tag, "_mem_d"}, mem_d, 0);
        chk({tag, "_qtag"}, {q_valid, q_first, q_last, q_lane_en}, 0);
    endtask

    task automatic coef_beat(input logic [15:0] d, input bit last);
        int addr = ref_loading ? ref_cnt : 0;
        bit fin  = last || (addr == 63);
        coef_valid = 1'b1;
        coef_data  = d;
        coef_last  = last;
        chk("coef_ready", coef_ready, 1);
        tick();
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        chk("wr_strobes", {mem_cen, mem_wen}, 2'b00);
        chk("wr_addr", mem_a0, addr);
        chk("wr_data", mem_d, d);
        ref_coef[addr] = d;
        if (fin) begin
            ref_ntaps   = addr + 1;
            ref_loaded  = 1'b1;
            ref_loading = 1'b0;
        end else begin
            ref_loaded  = 1'b0;
            ref_loading = 1'b1;
            ref_cnt     = addr + 1;
        end
        chk("ld_taps_loaded", taps_loaded, ref_loaded);
        if (fin) chk("ld_ntaps", ntaps, ref_ntaps);
        chk("ld_busy", busy, ref_loading);
    endtask

    task automatic sweep(input bit hold);
        int         n = (ref_ntaps + 5) / 6;
        int         k;
        logic [5:0] mask;
        sample_valid = 1'b1;
        #1;
        chk("sample_ready_idle", sample_ready, 1);
        tick();
        if (!hold) sample_valid = 1'b0;
        for (int j = 0; j <= n; j++) begin
            if (j > 0) tick();
            if (j < n) begin
                chk("run_busy", busy, 1);
                chk("run_strobes", {mem_cen, mem_wen}, 2'b01);
                chk("run_ready", {coef_ready, sample_ready}, 2'b00);
                for (int i = 0; i < 6; i++) chk("run_addr", ma[i], (6 * j + i) % 64);
            end else begin
                chk("end_busy", busy, 0);
                chk("end_cen", mem_cen, 1);
                chk("end_sample_ready", sample_ready, 1);
            end
            if (j == 0) begin
                chk("q_before_first", q_valid, 0);
            end else begin
                k = j - 1;
                mask = '0;
                for (int i = 0; i < 6; i++) if (6 * k + i < ref_ntaps) mask[i] = 1'b1;
                chk("q_valid", q_valid, 1);
                chk("q_first", q_first, k == 0);
                chk("q_last", q_last, k == n - 1);
                chk("q_lane_en", q_lane_en, mask);
                for (int i = 0; i < 6; i++) if (mask[i]) chk("q_data", cq[i], ref_coef[6 * k + i]);
            end
        end
    endtask

    initial begin
        int          n;
        logic [15:0] d;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_reset("idle0");

        // Full load with a known pattern, then a full sweep
        for (int j = 0; j < 64; j++) coef_beat(16'h1000 + 16'(j), j == 63);
        chk("full_ntaps", ntaps, 64);
        sweep(1'b0);

        // Short load of 7 taps
        for (int j = 0; j < 7; j++) coef_beat(16'($urandom), j == 6);
        chk("short_ntaps", ntaps, 7);
        sweep(1'b0);

        // Random-length loads, each swept twice back to back with sample_valid held
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 64);
            for (int j = 0; j < n; j++) coef_beat(16'($urandom), j == n - 1);
            sweep(1'b1);
            sweep(1'b0);
        end

        // Overlong load: beat 64 closes it, beats 65..66 open a new one
        for (int j = 0; j < 66; j++) coef_beat(16'($urandom), 1'b0);
        chk("overlong_taps_loaded", taps_loaded, 0);
        coef_beat(16'($urandom), 1'b1);
        chk("overlong_ntaps", ntaps, 3);
        sweep(1'b0);

        // Coefficient and sample offered together in IDLE
        d = 16'($urandom);
        coef_valid   = 1'b1;
        coef_data    = d;
        coef_last    = 1'b1;
        sample_valid = 1'b1;
        #1;
        chk("contend_sample_ready", sample_ready, 0);
        coef_beat(d, 1'b1);
        chk("contend_ntaps", ntaps, 1);
        sweep(1'b0);

        // Reset pulse during beat 5 of a full sweep
        for (int j = 0; j < 64; j++) coef_beat(16'($urandom), j == 63);
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (5) tick();
        chk("pre_rst_beat5", mem_a0, 30);
        #2 rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        ref_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_reset("post_rst");

        // Recovery after reset
        for (int j = 0; j < 10; j++) coef_beat(16'($urandom), j == 9);
        sweep(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmem_seq.md
# cmem_seq

Controller and read sequencer for the FIR core's 6-port, 64×16 coefficient memory (`cmem`). It loads coefficients from an upstream stream into `cmem` through its single write path. For each accepted input sample, it sweeps all loaded taps six at a time across the six read ports. It also emits a tag stream (valid, first, last, lane enables) aligned cycle-exactly with `cmem`'s Q0..Q5, which the MAC array uses to gate its lanes.

## Interface
- `DEPTH`, 64: coefficient words; equals 2^`AW`.
- `AW`, 6: `cmem` address width.
- `DW`, 16: coefficient width.
- `LANES`, 6: read ports driven in parallel.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `coef_valid` in 1: coefficient beat offered.
- `coef_ready` out 1: beat accepted when `coef_valid && coef_ready`.
- `coef_data` in `DW`: coefficient word.
- `coef_last` in 1: final beat of a load.
- `sample_valid` in 1: new input sample; starts one sweep.
- `sample_ready` out 1: sweep start accepted when `sample_valid && sample_ready`.
- `busy` out 1: the state is not IDLE.
- `taps_loaded` out 1: a complete coefficient set is resident.
- `ntaps` out `AW`+1: resident tap count, 1..64.
- `mem_d` out `DW`: drives `cmem` D.
- `mem_a0`..`mem_a5` out `AW` each: drive `cmem` A0..A5.
- `mem_wen`, `mem_cen` out 1 each: active-low (`ON`=0, `OFF`=1).
- `q_valid`, `q_first`, `q_last` out 1 each: tag for the Q data present this cycle.
- `q_lane_en` out `LANES`: bit i set means Qi holds a real tap.

## Operation
- States: IDLE, LOAD, RUN.
- All `mem_*` outputs are registered. `cmem` samples them on the next posedge, and its Q outputs are valid in the cycle after that.
- **IDLE**
  - `coef_ready`=1.
  - `sample_ready`=`taps_loaded`.
  - `mem_cen`=`mem_wen`=1.
- **Loading coefficients**
  - A coefficient beat accepted in IDLE or LOAD:
    - `mem_a0` ← write counter `waddr`; `mem_d` ← `coef_data`.
    - `mem_wen`=`mem_cen`=0 for exactly one cycle.
    - `waddr`++.
  - The first beat accepted from IDLE clears `waddr` to 0 and `taps_loaded` to 0, then enters LOAD.
  - A beat is final when `coef_last`=1 or it is the 64th beat (`waddr`=63).
  - On the final beat: `ntaps` ← `waddr`+1, `taps_loaded` ← 1, state → IDLE.
  - A 65th word is never written; a further beat starts a new load at address 0.
- **Running a sweep**
  - A sample accepted in IDLE moves the state to RUN with `base`=0.
  - Each RUN cycle issues one beat:
    - `mem_a`i = (`base`+i) mod 64.
    - `mem_cen`=0, `mem_wen`=1.
    - Lane i is enabled iff `base`+i < `ntaps`.
    - `base` += 6.
  - Beat count = ceil(`ntaps`/6), e.g. 11 beats for 64 taps.
  - The last beat returns the state to IDLE.
  - `base` is 7 bits wide, so there is no overflow; addresses of disabled lanes are don't-care but still computed mod 64.
- **Blocking between load and run**
  - In RUN: `coef_ready`=0 and `sample_ready`=0.
  - In LOAD: `sample_ready`=0.
- **Tag pipeline**
  - `first`, `last` and the lane enables of each beat are delayed 2 stages.
  - `q_valid` is the delayed beat-issued flag.
- **Reset** (asynchronous, takes effect at any point, including mid-load or mid-sweep):
  - State → IDLE.
  - `mem_cen`=`mem_wen`=1.
  - `mem_a*`=0, `mem_d`=0.
  - `taps_loaded`=0, `ntaps`=0.
  - `q_valid`=`q_first`=`q_last`=0, `q_lane_en`=0.
  - `waddr`=0, `base`=0, tag pipeline cleared.
  - `busy`=0, `coef_ready`=1, `sample_ready`=0.
  - A load interrupted by reset leaves `taps_loaded`=0.

## Timing
- **Write**: beat accepted at edge E → `mem_*` write controls held during cycle E+1 → `cmem` writes at edge E+1. Back-to-back beats give one write per cycle.
- **Sweep**: sample accepted at edge E → beat 0 on `mem_a*` in cycle E+1 → Q0..Q5 and `q_valid`/`q_first` in cycle E+2.
  - Beat k Q data is in cycle E+2+k; `q_last` accompanies the final beat.
- **Sample spacing**: `sample_ready` returns the cycle after the last beat is issued. Minimum spacing is ceil(`ntaps`/6)+1 cycles.
- **Simultaneous offers in IDLE**: `coef_valid` and `sample_valid` together → the load wins. `sample_ready` is combinationally forced to 0 when `coef_valid`=1 in IDLE.

## Structure
- Shared package `cmem_pkg`:
  - `CMEM_AW`=6, `CMEM_DW`=16, `CMEM_LANES`=6, `CMEM_DEPTH`=64.
  - `CMEM_ON`=1'b0, `CMEM_OFF`=1'b1.
  - State enum {IDLE, LOAD, RUN}.
  - Tag struct {valid, first, last, lane_en[5:0]}.
- One sub-module, `cmem_tag_pipe`: a 2-stage delay line for the tag struct, with async clear.

## Test plan
- **Full load**: 64 beats with `coef_data`=0x1000+n, `coef_last` on beat 63 → 64 writes at addresses 0..63; `ntaps`=64, `taps_loaded`=1; `coef_ready` never drops.
- **Full sweep**: sample with `ntaps`=64 → 11 beats.
  - Beat 10: addresses 60..63, 0, 1; `q_lane_en`=6'b001111.
  - `q_first` 2 cycles after acceptance; `q_last` 12 cycles after acceptance.
  - Q data matches the loaded coefficients.
- **Short load**: 7 beats ending with `coef_last` → `ntaps`=7. Sweep → 2 beats with lane enables 6'b111111 then 6'b000001.
- **Overlong load**: 66 beats without `coef_last` → beat 64 ends the load (`ntaps`=64); beats 65–66 start a new load at addresses 0–1 with `taps_loaded`=0.
- **Contention**: `coef_valid` and `sample_valid` in the same IDLE cycle → coefficient accepted, `sample_ready`=0. `sample_valid` during RUN → not accepted until `busy` falls.
- **Reset mid-sweep**: `rst` pulse during beat 5 → all outputs return to the reset values asynchronously, including `taps_loaded`=0, `q_valid`=0 and `mem_cen`=1.
